// File: rtl/adder_pkg.sv
// Shared constants for the ripple-carry adder slice.
// Operand width used as the default for adder_4bit.
package adder_pkg;
    localparam int WIDTH = 4;
endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used as a link in the ripple-carry chain.
// Purely combinational, zero latency, no handshake.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);
endmodule

// File: rtl/adder_4bit.sv
// Ripple-carry adder with combinational sum/carry/overflow and registered copies.
// Combinational outputs have zero latency; registered outputs follow one clk later; no backpressure.
module adder_4bit #(
    parameter int WIDTH = adder_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    input  logic             clk,
    input  logic             reset,
    output logic             ovf,
    output logic [WIDTH-1:0] sum_q,
    output logic             carry_q,
    output logic             ovf_q
);
    import adder_pkg::*;

    // c[i] is the carry into bit i; c[WIDTH] is the carry-out.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum_d;
    logic             carry_d;
    logic             ovf_d;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder u_fa (
            .a  (in1[i]),
            .b  (in2[i]),
            .ci (c[i]),
            .s  (out[i]),
            .co (c[i+1])
        );
    end

    assign carry = c[WIDTH];
    // Signed overflow: carry into the sign bit disagrees with carry out of it.
    assign ovf   = c[WIDTH-1] ^ c[WIDTH];

    assign sum_d   = out;
    assign carry_d = carry;
    assign ovf_d   = ovf;

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_adder_4bit.sv
// Directed-vector bench for adder_4bit: reset, combinational vectors, registered path, reset priority, full sweep.
module tb_adder_4bit;
    logic       clk;
    logic       reset;
    logic [3:0] in1;
    logic [3:0] in2;
    logic       cin;
    logic [3:0] out;
    logic       carry;
    logic       ovf;
    logic [3:0] sum_q;
    logic       carry_q;
    logic       ovf_q;

    int tests;
    int fails;

    adder_4bit #(.WIDTH(4)) dut (
        .in1     (in1),
        .in2     (in2),
        .cin     (cin),
        .out     (out),
        .carry   (carry),
        .clk     (clk),
        .reset   (reset),
        .ovf     (ovf),
        .sum_q   (sum_q),
        .carry_q (carry_q),
        .ovf_q   (ovf_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; in1 = 4'd3; in2 = 4'd4; cin = 1'b0;
        @(posedge clk); #1;
        tests++;
        if ({sum_q, carry_q, ovf_q} !== 6'b0) begin
            fails++;
            $display("FAIL reset_regs: got sum_q=%0d carry_q=%0b ovf_q=%0b, want 0 0 0", sum_q, carry_q, ovf_q);
        end
        tests++;
        if (out !== 4'd7 || carry !== 1'b0) begin
            fails++;
            $display("FAIL reset_comb_live: got out=%0d carry=%0b, want 7 0", out, carry);
        end
    endtask

    task automatic test_vectors();
        logic [3:0] a_t [6] = '{4'd12, 4'd12, 4'd8, 4'd15, 4'd6, 4'd15};
        logic [3:0] b_t [6] = '{4'd15, 4'd2,  4'd3, 4'd1,  4'd7, 4'd15};
        logic       c_t [6] = '{1'b0,  1'b0,  1'b0, 1'b0,  1'b0, 1'b1};
        logic [3:0] o_t [6] = '{4'd11, 4'd14, 4'd11, 4'd0, 4'd13, 4'd15};
        logic       k_t [6] = '{1'b1,  1'b0,  1'b0, 1'b1,  1'b0, 1'b1};
        logic       v_t [6] = '{1'b0,  1'b0,  1'b0, 1'b0,  1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in1 = a_t[i]; in2 = b_t[i]; cin = c_t[i];
            #1;
            tests++;
            if (out !== o_t[i] || carry !== k_t[i] || ovf !== v_t[i]) begin
                fails++;
                $display("FAIL vector_%0d: %0d+%0d+%0b got out=%0d carry=%0b ovf=%0b, want %0d %0b %0b",
                         i, a_t[i], b_t[i], c_t[i], out, carry, ovf, o_t[i], k_t[i], v_t[i]);
            end
        end
    endtask

    task automatic test_register();
        @(negedge clk);
        reset = 1'b0; in1 = 4'd0; in2 = 4'd0; cin = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (sum_q !== 4'd0) begin
            fails++;
            $display("FAIL reg_zero: got sum_q=%0d, want 0", sum_q);
        end
        @(negedge clk);
        in1 = 4'd6; in2 = 4'd7;
        #1;
        tests++;
        if (sum_q !== 4'd0 || out !== 4'd13) begin
            fails++;
            $display("FAIL reg_hold_before_edge: got sum_q=%0d out=%0d, want 0 13", sum_q, out);
        end
        @(posedge clk); #1;
        tests++;
        if (sum_q !== 4'd13 || carry_q !== 1'b0 || ovf_q !== 1'b1) begin
            fails++;
            $display("FAIL reg_capture: got sum_q=%0d carry_q=%0b ovf_q=%0b, want 13 0 1", sum_q, carry_q, ovf_q);
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        in1 = 4'd12; in2 = 4'd15; cin = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (sum_q !== 4'd11 || carry_q !== 1'b1 || ovf_q !== 1'b0) begin
            fails++;
            $display("FAIL load_11: got sum_q=%0d carry_q=%0b ovf_q=%0b, want 11 1 0", sum_q, carry_q, ovf_q);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (sum_q !== 4'd0 || carry_q !== 1'b0 || ovf_q !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_regs: got sum_q=%0d carry_q=%0b ovf_q=%0b, want 0 0 0", sum_q, carry_q, ovf_q);
        end
        tests++;
        if (out !== 4'd11 || carry !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset_comb: got out=%0d carry=%0b, want 11 1", out, carry);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (sum_q !== 4'd11 || carry_q !== 1'b1) begin
            fails++;
            $display("FAIL release_capture: got sum_q=%0d carry_q=%0b, want 11 1", sum_q, carry_q);
        end
    endtask

    task automatic test_sweep();
        logic [4:0] exp_sum;
        logic       exp_ovf;
        int         sweep_fails;
        sweep_fails = 0;
        for (int i = 0; i < 512; i++) begin
            in1 = i[3:0]; in2 = i[7:4]; cin = i[8];
            #1;
            exp_sum = {1'b0, i[3:0]} + {1'b0, i[7:4]} + {4'b0, i[8]};
            exp_ovf = (i[3] == i[7]) && (exp_sum[3] != i[3]);
            tests++;
            if ({carry, out} !== exp_sum) begin
                fails++;
                sweep_fails++;
                if (sweep_fails <= 8)
                    $display("FAIL sweep_sum: %0d+%0d+%0b got %0d, want %0d", i[3:0], i[7:4], i[8], {carry, out}, exp_sum);
            end
            tests++;
            if (ovf !== exp_ovf) begin
                fails++;
                sweep_fails++;
                if (sweep_fails <= 8)
                    $display("FAIL sweep_ovf: %0d+%0d+%0b got %0b, want %0b", i[3:0], i[7:4], i[8], ovf, exp_ovf);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        in1 = '0; in2 = '0; cin = 1'b0;
        test_reset();
        test_vectors();
        test_register();
        test_mid_reset();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
